// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch states, reset PC, instruction field positions and opcodes
package rv_pkg;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_WAIT_DROP} fetch_state_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with reset, sequential increment and word-aligned redirect
module pc_reg #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] pc_q, pc_d;
    always_comb begin
        pc_d = redirect_valid ? {redirect_target[XLEN-1:2], 2'b00} : inc ? pc_q + XLEN'(4) : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end
    assign pc = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with one-entry output buffer and redirect drop
module fetch_stage import rv_pkg::*; #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);
    fetch_state_t    state_q, state_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d, ipc4_q, ipc4_d, pc;
    logic            req, hs, resp, load;

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .inc(hs),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .pc(pc)
    );

    // pc already points past the in-flight request, so the buffered address is pc-4
    always_comb begin
        req     = state_q == S_REQ && !rst && (!valid_q || instr_ready);
        hs      = req && imem_req_ready;
        resp    = state_q != S_REQ && imem_resp_valid;
        load    = state_q == S_WAIT && imem_resp_valid && !redirect_valid;
        state_d = resp ? S_REQ
                : hs ? (redirect_valid ? S_WAIT_DROP : S_WAIT)
                : (state_q == S_WAIT && redirect_valid) ? S_WAIT_DROP : state_q;
        valid_d = !redirect_valid && (load || (valid_q && !instr_ready));
        instr_d = load ? imem_resp_data : instr_q;
        ipc_d   = load ? pc - XLEN'(4) : ipc_q;
        ipc4_d  = load ? pc : ipc4_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
        end
    end

    assign imem_req_valid = req;
    assign imem_req_addr  = pc;
    assign instr_valid    = valid_q;
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;
    assign instr_pc_plus4 = ipc4_q;
    assign opcode = instr_q[OPCODE_LSB +: 7];
    assign rd     = instr_q[RD_LSB +: 5];
    assign funct3 = instr_q[FUNCT3_LSB +: 3];
    assign rs1    = instr_q[RS1_LSB +: 5];
    assign rs2    = instr_q[RS2_LSB +: 5];
    assign funct7 = instr_q[FUNCT7_LSB +: 7];
endmodule
